// File: rtl/ram_fifo_ctrl_if.sv
// Push/pop handshake bundle between a producer/consumer and ram_fifo_ctrl.
// The master side drives data and valid/ready requests; the slave side is the controller.
interface ram_fifo_ctrl_if #(
  parameter int SIZE   = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
);
  logic [SIZE-1:0] wr_data;
  logic            wr_valid;
  logic            wr_ready;
  logic [SIZE-1:0] rd_data;
  logic            rd_valid;
  logic            rd_ready;
  logic [ADDR_W:0] count;

  modport master (
    output wr_data, wr_valid, rd_ready,
    input  wr_ready, rd_data, rd_valid, count
  );

  modport slave (
    input  wr_data, wr_valid, rd_ready,
    output wr_ready, rd_data, rd_valid, count
  );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// First-word-fall-through FIFO controller driving an external simple dual-port RAM.
// Define FIFO_CTRL_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module ram_fifo_ctrl #(
  parameter int SIZE   = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  ram_fifo_ctrl_if.slave    fifo,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [SIZE-1:0]   ram_wdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [SIZE-1:0]   ram_rdata
`ifdef FIFO_CTRL_ERR_FLAGS_EN
  ,
  output logic              overflow,
  output logic              underflow
`endif
);

  logic [ADDR_W:0] wptr;
  logic [ADDR_W:0] rptr;
  logic [ADDR_W:0] rptr_next;
  logic [ADDR_W:0] count;
  logic            rd_valid_q;
  logic            full;
  logic            push;
  logic            pop;

  assign count     = wptr - rptr;
  assign full      = (count == (ADDR_W+1)'(DEPTH));
  assign push      = fifo.wr_valid && fifo.wr_ready;
  assign pop       = rd_valid_q && fifo.rd_ready;
  assign rptr_next = rptr + {{ADDR_W{1'b0}}, pop};

  assign fifo.wr_ready = !full && !rst;
  assign fifo.rd_valid = rd_valid_q;
  assign fifo.rd_data  = ram_rdata;
  assign fifo.count    = count;

  assign ram_we    = push;
  assign ram_waddr = wptr[ADDR_W-1:0];
  assign ram_wdata = fifo.wr_data;
  // Reading at rptr_next keeps the head re-read while stalled and prefetches the next word on a pop.
  assign ram_raddr = rptr_next[ADDR_W-1:0];

  // The pre-edge wptr is used so a word is never read on the same edge that writes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      rptr       <= rptr_next;
      rd_valid_q <= (wptr != rptr_next);
    end
  end

`ifdef FIFO_CTRL_ERR_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (fifo.wr_valid && !fifo.wr_ready) begin
        overflow <= 1'b1;
      end
      if (fifo.rd_ready && !rd_valid_q) begin
        underflow <= 1'b1;
      end
    end
  end
`endif

endmodule
